fm_tune_controller: RTL and testbench

Sweep-and-lock controller for the FM demodulator's centre-frequency control word. On a start pulse it steps `ctr_ctrl` through a programmed number of points. At each point it waits for the NCO/averager chain to settle, then accumulates the magnitude of the demodulated output. It selects the point with the smallest accumulated magnitude (phase detector nearest quadrature) and parks `ctr_ctrl` there. It sits between the host/config logic and the demodulator's `ctr_ctrl` input and observes the demodulator's `demodulated` output.

---
 rtl/fm_tune_controller.sv | 139 +++++++++++++
 tb/tb_fm_tune_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fm_tune_controller.sv
// Sweep-and-lock controller for the FM demodulator centre-frequency word:
// steps ctr_ctrl across N points, measures |demodulated| at each, parks at the minimum.
module fm_tune_controller #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MEASURE_LOG2  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] start_ctrl,
  input  logic [31:0] step_ctrl,
  input  logic [7:0]  num_steps,
  input  logic [7:0]  demodulated,
  output logic [31:0] ctr_ctrl,
  output logic        busy,
  output logic        done,
  output logic        locked,
  output logic [31:0] best_ctrl,
  output logic [23:0] best_metric
);

  localparam int unsigned AW = 8 + MEASURE_LOG2;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] MEAS_LAST   = CW'((1 << MEASURE_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, MEASURE, COMPARE, STEP, FINISH
  } state_t;

  state_t          state;
  logic            start_q;
  logic            abort_q;
  logic [31:0]     start_word;
  logic [31:0]     step_q;
  logic [7:0]      num_q;
  logic [7:0]      idx;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [7:0]      mag;
  logic            accept_c;

  // |demodulated|; -128 maps to 8'h80 = 128 unsigned
  always_comb mag = demodulated[7] ? (~demodulated + 8'd1) : demodulated;

  // start is registered once before the FSM acts on it; busy or a pending start blocks a new one
  always_comb accept_c = start && (num_steps != 8'd0) && !abort && !busy && !start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      start_word  <= 32'd0;
      step_q      <= 32'd0;
      num_q       <= 8'd0;
      idx         <= 8'd0;
      cnt         <= '0;
      acc         <= '0;
      ctr_ctrl    <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      locked      <= 1'b0;
      best_ctrl   <= 32'd0;
      best_metric <= 24'hFFFFFF;
    end else begin
      done    <= 1'b0;
      start_q <= accept_c;
      abort_q <= abort;
      if (accept_c) begin
        start_word <= start_ctrl;
        step_q     <= step_ctrl;
        num_q      <= num_steps;
      end

      if (abort_q && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_q && !abort_q) begin
              ctr_ctrl    <= start_word;
              busy        <= 1'b1;
              locked      <= 1'b0;
              best_metric <= 24'hFFFFFF;
              idx         <= 8'd0;
              cnt         <= '0;
              state       <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              acc   <= '0;
              state <= MEASURE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          MEASURE: begin
            acc <= acc + AW'(mag);
            if (cnt == MEAS_LAST) begin
              cnt   <= '0;
              state <= COMPARE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          COMPARE: begin
            if (24'(acc) < best_metric) begin
              best_metric <= 24'(acc);
              best_ctrl   <= ctr_ctrl;
            end
            state <= STEP;
          end
          STEP: begin
            // the last point finishes here so done/lock land one point-period after the previous step
            if (idx == num_q - 8'd1) begin
              ctr_ctrl <= best_ctrl;
              done     <= 1'b1;
              locked   <= 1'b1;
              busy     <= 1'b0;
              state    <= FINISH;
            end else begin
              ctr_ctrl <= ctr_ctrl + step_q;
              idx      <= idx + 8'd1;
              state    <= SETTLE;
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm_tune_controller.sv
// Self-checking bench for fm_tune_controller: directed scenarios plus random
// stimulus, compared every cycle against a timeline-based reference model.
module tb_fm_tune_controller;

  localparam int S  = 4;
  localparam int M  = 2;
  localparam int NS = 1 << M;
  localparam int P  = S + NS + 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [31:0] start_ctrl, step_ctrl;
  logic [7:0]  num_steps;
  logic [7:0]  demodulated;
  logic [31:0] ctr_ctrl, best_ctrl;
  logic        busy, done, locked;
  logic [23:0] best_metric;

  int n_cmp = 0;
  int n_err = 0;

  fm_tune_controller #(.SETTLE_CYCLES(S), .MEASURE_LOG2(M)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .start_ctrl(start_ctrl), .step_ctrl(step_ctrl), .num_steps(num_steps),
    .demodulated(demodulated), .ctr_ctrl(ctr_ctrl), .busy(busy), .done(done),
    .locked(locked), .best_ctrl(best_ctrl), .best_metric(best_metric)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a sweep is a timeline starting at edge t0; position within
  // a point decides whether the edge samples, compares or steps.
  longint      e, t0;
  bit          m_active, m_busy, m_done, m_locked;
  bit          m_sp, m_ap, busy_old, sp_old, ap_old;
  logic [31:0] m_ctr, m_best_ctrl, m_step, p_ctrl, p_step;
  int          m_best_metric, m_acc, m_num, p_num, d, pi, ph;

  function automatic int absv(input logic [7:0] v);
    int x;
    x = $signed(v);
    return (x < 0) ? -x : x;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e = 0; m_active = 0; m_busy = 0; m_done = 0; m_locked = 0;
      m_sp = 0; m_ap = 0; m_ctr = 0; m_best_ctrl = 0; m_best_metric = 24'hFFFFFF;
      m_acc = 0;
    end else begin
      e++;
      busy_old = m_busy; sp_old = m_sp; ap_old = m_ap;
      m_done = 0;
      if (m_active) begin
        if (ap_old) begin
          m_active = 0; m_busy = 0;
        end else begin
          d  = int'(e - t0);
          pi = (d - 1) / P;
          ph = (d - 1) % P + 1;
          if (ph >= S + 1 && ph <= S + NS) m_acc += absv(demodulated);
          else if (ph == S + NS + 1) begin
            if (m_acc < m_best_metric) begin
              m_best_metric = m_acc; m_best_ctrl = m_ctr;
            end
          end else if (ph == P) begin
            if (pi == m_num - 1) begin
              m_ctr = m_best_ctrl; m_done = 1; m_locked = 1; m_busy = 0; m_active = 0;
            end else m_ctr = m_ctr + m_step;
            m_acc = 0;
          end
        end
      end else if (sp_old && !ap_old) begin
        m_active = 1; t0 = e; m_ctr = p_ctrl; m_step = p_step; m_num = p_num;
        m_busy = 1; m_locked = 0; m_best_metric = 24'hFFFFFF; m_acc = 0;
      end
      m_sp = start && (num_steps != 0) && !abort && !busy_old && !sp_old;
      if (m_sp) begin
        p_ctrl = start_ctrl; p_step = step_ctrl; p_num = int'(num_steps);
      end
      m_ap = abort;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      chk("ctr_ctrl", ctr_ctrl, m_ctr);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("best_ctrl", best_ctrl, m_best_ctrl);
      chk("best_metric", 32'(best_metric), 32'(m_best_metric));
    end
  end

  // Pulse start for one cycle; returns at the negedge after sample edge k
  task automatic pulse_start(input logic [31:0] c, input logic [31:0] s, input logic [7:0] n);
    start = 1'b1; start_ctrl = c; step_ctrl = s; num_steps = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive one demod value per point for n points; optional stray start during point 1
  task automatic drive_points(input int v0, input int v1, input int v2, input int n, input bit inject);
    int v;
    for (int p = 0; p < n; p++) begin
      v = (p == 0) ? v0 : (p == 1) ? v1 : v2;
      for (int c = 0; c < P; c++) begin
        demodulated = 8'(v);
        if (inject && p == 1 && c == 2) begin
          start = 1'b1; start_ctrl = 32'hDEAD0000; num_steps = 8'd1;
        end else start = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 0; abort = 0; start_ctrl = 0; step_ctrl = 0;
    num_steps = 0; demodulated = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctr", ctr_ctrl, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_best_metric", 32'(best_metric), 32'hFFFFFF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-point sweep
    pulse_start(32'h1000, 32'h100, 8'd3);
    chk("tp_busy_before", 32'(busy), 32'd0);
    @(negedge clk);
    chk("tp_busy", 32'(busy), 32'd1);
    chk("tp_ctr_first", ctr_ctrl, 32'h1000);
    drive_points(20, -5, 40, 3, 1'b0);
    chk("tp_done", 32'(done), 32'd1);
    chk("tp_best_metric", 32'(best_metric), 32'd20);
    chk("tp_best_ctrl", best_ctrl, 32'h1100);
    chk("tp_ctr_lock", ctr_ctrl, 32'h1100);
    chk("tp_locked", 32'(locked), 32'd1);

    // Back-to-back: start in the cycle done is high
    pulse_start(32'h2000, 32'h10, 8'd2);
    @(negedge clk);
    chk("bb_locked_clr", 32'(locked), 32'd0);
    chk("bb_metric_rst", 32'(best_metric), 32'hFFFFFF);
    chk("bb_ctr", ctr_ctrl, 32'h2000);
    drive_points(7, 3, 0, 2, 1'b0);
    chk("bb_done", 32'(done), 32'd1);
    chk("bb_best_ctrl", best_ctrl, 32'h2010);
    chk("bb_best_metric", 32'(best_metric), 32'd12);
    repeat (3) @(negedge clk);

    // Wrap and tie
    pulse_start(32'hFFFFFF80, 32'h80, 8'd2);
    @(negedge clk);
    demodulated = 8'h80;
    repeat (P) @(negedge clk);
    chk("wr_ctr_wrap", ctr_ctrl, 32'h0);
    repeat (P) @(negedge clk);
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_metric", 32'(best_metric), 32'd512);
    chk("wr_best_ctrl", best_ctrl, 32'hFFFFFF80);
    repeat (3) @(negedge clk);

    // num_steps = 0 is ignored
    pulse_start(32'h5555, 32'h1, 8'd0);
    repeat (3) @(negedge clk);
    chk("n0_busy", 32'(busy), 32'd0);

    // Start while busy is ignored
    pulse_start(32'h1000, 32'h100, 8'd3);
    @(negedge clk);
    drive_points(20, -5, 40, 3, 1'b1);
    chk("sb_done", 32'(done), 32'd1);
    chk("sb_best_ctrl", best_ctrl, 32'h1100);
    repeat (3) @(negedge clk);

    // Abort during point-1 MEASURE
    pulse_start(32'h1000, 32'h100, 8'd3);
    @(negedge clk);
    demodulated = 8'd9;
    repeat (P + S + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ctr_hold", ctr_ctrl, 32'h1100);
    chk("ab_locked", 32'(locked), 32'd0);
    repeat (P) @(negedge clk);

    // abort and start in the same idle cycle
    abort = 1'b1;
    pulse_start(32'h7000, 32'h1, 8'd2);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abst_busy", 32'(busy), 32'd0);

    // Reset mid-sweep
    pulse_start(32'h3000, 32'h40, 8'd3);
    repeat (P + 3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_ctr", ctr_ctrl, 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_locked", 32'(locked), 32'd0);
    chk("rm_best_metric", 32'(best_metric), 32'hFFFFFF);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      demodulated = 8'($urandom);
      start       = ($urandom_range(0, 7) == 0);
      start_ctrl  = $urandom;
      step_ctrl   = $urandom;
      num_steps   = 8'($urandom_range(0, 4));
      abort       = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    start = 0; abort = 0;
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
